// File: rtl/clm_inv_sequencer.sv
// Masked GF(2^8) inverse sequencer: drives one serial CLM multiplier through the
// fixed 11-step x^254 addition chain on (8+d)-bit redundant operands.
module clm_inv_sequencer #(
    parameter int unsigned d = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8+d-1:0]   in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8+d-1:0]   out_y,
    output logic             mul_drdy_i,
    output logic [8+d-1:0]   mul_p1,
    output logic [8+d-1:0]   mul_p2,
    input  logic             mul_drdy_o,
    input  logic [8+d-1:0]   mul_out,
    output logic             busy
);

    localparam int unsigned W         = 8 + d;
    localparam int unsigned N_STEPS   = 11;
    localparam int unsigned SW        = 4;
    localparam logic [SW-1:0] LAST_STEP = SW'(N_STEPS - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [SW-1:0] step;
    logic [SW-1:0] step_nx;
    logic [W-1:0]  rx, r2, r3, r12, acc;
    logic [W-1:0]  r2_c, r3_c, r12_c, acc_c;
    logic [W-1:0]  p1_c, p2_c;

    assign step_nx = step + SW'(1);
    assign out_y   = acc;

    // Register file as it will look after this cycle's product capture
    always_comb begin
        r2_c  = r2;
        r3_c  = r3;
        r12_c = r12;
        acc_c = acc;
        if (state == S_WAIT && mul_drdy_o) begin
            case (step)
                SW'(0):  r2_c  = mul_out;
                SW'(1):  r3_c  = mul_out;
                SW'(3):  r12_c = mul_out;
                default: acc_c = mul_out;
            endcase
        end
    end

    // Operand pair of the following step, forwarded from the freshly captured product
    always_comb begin
        p1_c = acc_c;
        p2_c = acc_c;
        case (step_nx)
            SW'(1):  begin p1_c = r2_c;  p2_c = rx;    end
            SW'(2):  begin p1_c = r3_c;  p2_c = r3_c;  end
            SW'(4):  begin p1_c = r12_c; p2_c = r3_c;  end
            SW'(9):  begin p1_c = acc_c; p2_c = r12_c; end
            SW'(10): begin p1_c = acc_c; p2_c = r2_c;  end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            step       <= '0;
            rx         <= '0;
            r2         <= '0;
            r3         <= '0;
            r12        <= '0;
            acc        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            mul_drdy_i <= 1'b0;
            mul_p1     <= '0;
            mul_p2     <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        rx         <= in_x;
                        step       <= '0;
                        mul_p1     <= in_x;
                        mul_p2     <= in_x;
                        mul_drdy_i <= 1'b1;
                        in_ready   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    mul_drdy_i <= 1'b0;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    // done is stale until the issue edge clears it, so it is only trusted here
                    if (mul_drdy_o) begin
                        r2  <= r2_c;
                        r3  <= r3_c;
                        r12 <= r12_c;
                        acc <= acc_c;
                        if (step == LAST_STEP) begin
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            step       <= step_nx;
                            mul_p1     <= p1_c;
                            mul_p2     <= p2_c;
                            mul_drdy_i <= 1'b1;
                            state      <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/clm_inv_sequencer.md
Name: clm_inv_sequencer

Overview:
- Initiator side of the CLM multiplier request/response interface.
- Computes the masked GF(2^8) inverse x^254 in the redundant (8+d)-bit representation by driving one serial CLM multiplier through a fixed 11-step addition chain.
- Sits between the S-box datapath (valid/ready front end) and the multiplier.
- Collects each product and feeds it back as operands for the next step.

Parameters:
d, 2, redundancy degree; state width W = 8+d bits.
N_STEPS, 11, multiplications in the chain (fixed; not to be overridden).

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  input element x valid
in_ready  out  1  block can accept x
in_x  in  W  masked input element
out_valid  out  1  result x^254 valid
out_ready  in  1  consumer accepts result
out_y  out  W  masked result
mul_drdy_i  out  1  request pulse to multiplier
mul_p1  out  W  operand 1
mul_p2  out  W  operand 2
mul_drdy_o  in  1  multiplier done (level; stays high until next request)
mul_out  in  W  multiplier product
busy  out  1  chain in progress

Behaviour:
- Reset (rst low, async): state IDLE; in_ready=1; out_valid=0; out_y=0; mul_drdy_i=0; mul_p1=mul_p2=0; busy=0; step counter=0; all operand registers (rx, r2, r3, r12, acc) = 0.
- Reset mid-chain aborts immediately. The partial result is discarded and no out_valid is produced.
- States:
  - IDLE: in_ready=1. On in_valid: rx<=in_x, step<=0, go to ISSUE.
  - ISSUE: mul_drdy_i=1 for exactly this cycle, with mul_p1/mul_p2 driven from the step's operand pair. Go to WAIT.
  - WAIT: mul_drdy_i=0, operands held stable. On mul_drdy_o=1, capture mul_out into the step's destination register.
    - If step==10: go to DONE.
    - Else: step<=step+1, go to ISSUE.
  - DONE: out_valid=1, out_y=acc. On out_ready: go to IDLE.
- in_ready=1 only in IDLE; in_valid is ignored in all other states. busy=1 in ISSUE and WAIT.
- mul_drdy_o is level and stale from the previous request. It is sampled only in WAIT, which is always entered after the issue edge has cleared it.
- Chain (step: p1*p2 -> dest):
  0: x*x -> r2
  1: r2*x -> r3
  2: r3*r3 -> acc (x^6)
  3: acc*acc -> r12
  4: r12*r3 -> acc (x^15)
  5: acc*acc -> acc (x^30)
  6: acc*acc -> acc (x^60)
  7: acc*acc -> acc (x^120)
  8: acc*acc -> acc (x^240)
  9: acc*r12 -> acc (x^252)
  10: acc*r2 -> acc (x^254)
- Operand order is fixed as listed (p1 first); the verifier checks it.
- Timing with the serial CLM multiplier:
  - mul_drdy_o is seen high 9+d edges after the request edge.
  - One round takes 10+d cycles.
  - in_valid accept edge to out_valid high = 11*(10+d) cycles (132 for d=2).
- Back-pressure: in DONE, out_y and out_valid are held indefinitely until out_ready. out_valid and out_ready high in the same cycle completes the transfer. A new in_valid is accepted no earlier than the following cycle (IDLE).
- No arithmetic is done locally; all products come from the multiplier. The block only stores and routes W-bit values.

Test Plan:
- Reset: hold rst low, then release → all outputs at reset values. Assert rst low mid-WAIT at step 5 → outputs return to reset values asynchronously, no out_valid, multiplier request never re-pulsed.
- Functional, d=2, P=0x11B, zero mask: in_x = embedding of 0x53 → out_y reduces to 0xCA. in_x=1 → out_y=1. in_x=0 → out_y=0.
- Latency, d=2: in_valid accepted at edge N → out_valid rises exactly at edge N+132. Exactly 11 one-cycle mul_drdy_i pulses, spaced 12 cycles apart.
- Operand order: tagging multiplier model → p1/p2 pairs match the chain table for steps 0..10.
- Handshake: hold out_ready=0 for 50 cycles → out_y stable, in_ready=0, in_valid ignored. Then out_ready=1 → in_ready=1 next cycle and a back-to-back second input completes correctly.
- Stale done: leave mul_drdy_o high after a response. The sequencer must not advance before the multiplier's 9+d-cycle completion; a model asserting mul_drdy_o late (e.g. 20 cycles) stretches every WAIT correspondingly.
